// File: rtl/conv3x3_relu_stream_pkg.sv
// Shared CNN types: image geometry, pixel/weight/accumulator types and the stream FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a; consumers are push-only streams.
package conv3x3_relu_stream_pkg;

    localparam int CNN_KERNEL       = 3;
    localparam int CNN_IMG_WIDTH    = 20;
    localparam int CNN_IMG_HEIGHT   = 20;
    localparam int CNN_PIX_WIDTH    = 8;
    localparam int CNN_WEIGHT_WIDTH = 8;
    localparam int CNN_DATA_WIDTH   = 24;
    // 9 signed products of (PIX+1)x(WEIGHT) bits need 4 guard bits for the sum.
    localparam int CNN_ACC_WIDTH    = CNN_PIX_WIDTH + CNN_WEIGHT_WIDTH + 5;

    typedef logic        [CNN_PIX_WIDTH-1:0]    pix_t;
    typedef logic signed [CNN_WEIGHT_WIDTH-1:0] weight_t;
    typedef logic signed [CNN_ACC_WIDTH-1:0]    acc_t;
    typedef logic        [CNN_DATA_WIDTH-1:0]   data_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/conv3x3_relu_stream_line_buffer.sv
// Single-row delay line: dout_o is the sample pushed DEPTH enabled cycles earlier.
// Latency: DEPTH enabled pushes; output is combinational from the oldest entry.
// Backpressure: none; en_i freezes the whole row while the stream has a gap.
module line_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 20
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Shift one row position per accepted pixel; contents need no reset because
    // no result is formed until a fresh frame has refilled both rows.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            mem_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv3x3_relu_stream.sv
// 3x3 signed-weight convolution + ReLU over a raster pixel stream, one result per full window.
// Latency: valid_out exactly 2 cycles after the pixel completing the window (window reg, MAC reg).
// Backpressure: none; every valid_in pixel is consumed (except when w_load wins in IDLE).
module conv3x3_relu_stream
    import conv3x3_relu_stream_pkg::*;
#(
    parameter int PIX_WIDTH    = CNN_PIX_WIDTH,
    parameter int WEIGHT_WIDTH = CNN_WEIGHT_WIDTH,
    parameter int DATA_WIDTH   = CNN_DATA_WIDTH,
    parameter int IMG_WIDTH    = CNN_IMG_WIDTH,
    parameter int IMG_HEIGHT   = CNN_IMG_HEIGHT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           w_load,
    input  logic signed [WEIGHT_WIDTH-1:0] w_data,
    input  logic                           valid_in,
    input  logic        [PIX_WIDTH-1:0]    pixel_in,
    output logic                           valid_out,
    output logic        [DATA_WIDTH-1:0]   pixel_out,
    output logic                           frame_done,
    output logic                           busy
);

    localparam int NTAP  = CNN_KERNEL * CNN_KERNEL;
    localparam int PROD_W = PIX_WIDTH + WEIGHT_WIDTH + 1;
    localparam int ACC_W = PROD_W + 4;
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    state_t                         state_q, state_d;
    logic signed [WEIGHT_WIDTH-1:0] w_q [NTAP];
    logic        [3:0]              widx_q;
    logic        [COL_W-1:0]        col_q;
    logic        [ROW_W-1:0]        row_q;
    logic        [PIX_WIDTH-1:0]    win_q [NTAP];
    logic                           win_vld_q, win_last_q;
    logic                           valid_q, done_q;
    logic        [DATA_WIDTH-1:0]   pix_out_q;
    logic        [PIX_WIDTH-1:0]    lb0_out, lb1_out;
    logic                           w_wr, accept, col_last, row_last, last_pix, win_full;
    logic signed [ACC_W-1:0]        acc_sum;
    logic        [ACC_W-1:0]        relu_val;

    // A weight write in IDLE steals the cycle: the coincident pixel is dropped.
    assign w_wr     = (state_q == ST_IDLE) && w_load;
    assign accept   = valid_in && !w_wr;
    assign col_last = (col_q == COL_W'(IMG_WIDTH - 1));
    assign row_last = (row_q == ROW_W'(IMG_HEIGHT - 1));
    assign last_pix = col_last && row_last;
    assign win_full = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

    // Row r-1 and row r-2 at the current column.
    line_buffer #(.WIDTH(PIX_WIDTH), .DEPTH(IMG_WIDTH)) u_lb0 (
        .clk_i(clk), .en_i(accept), .din_i(pixel_in), .dout_o(lb0_out)
    );
    line_buffer #(.WIDTH(PIX_WIDTH), .DEPTH(IMG_WIDTH)) u_lb1 (
        .clk_i(clk), .en_i(accept), .din_i(lb0_out), .dout_o(lb1_out)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: DRAIN waits for the frame's last result unless a new frame starts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_RUN;
            ST_RUN:   if (accept && last_pix) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (accept)      state_d = ST_RUN;
                else if (done_q) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Weight bank, written sequentially in IDLE with a wrapping index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAP; i++) w_q[i] <= '0;
            widx_q <= '0;
        end else if (w_wr) begin
            w_q[widx_q] <= w_data;
            widx_q      <= (widx_q == 4'd8) ? 4'd0 : widx_q + 4'd1;
        end
    end

    // Raster position of the next pixel, advanced only by accepted pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= row_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    // Stage 1: shift the 3x3 window left and flag windows that lie fully inside the image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAP; i++) win_q[i] <= '0;
            win_vld_q  <= 1'b0;
            win_last_q <= 1'b0;
        end else begin
            win_vld_q  <= accept && win_full;
            win_last_q <= accept && last_pix;
            if (accept) begin
                for (int r = 0; r < CNN_KERNEL; r++) begin
                    win_q[r*3+0] <= win_q[r*3+1];
                    win_q[r*3+1] <= win_q[r*3+2];
                end
                win_q[2] <= lb1_out;
                win_q[5] <= lb0_out;
                win_q[8] <= pixel_in;
            end
        end
    end

    // Signed MAC of the registered window: pixels are zero-extended, weights sign-extended.
    always_comb begin
        logic signed [PROD_W-1:0] prod;
        acc_sum = '0;
        prod    = '0;
        for (int i = 0; i < NTAP; i++) begin
            prod    = $signed({{(WEIGHT_WIDTH + 1){1'b0}}, win_q[i]})
                    * $signed({{(PIX_WIDTH + 1){w_q[i][WEIGHT_WIDTH-1]}}, w_q[i]});
            acc_sum = acc_sum + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

    assign relu_val = acc_sum[ACC_W-1] ? '0 : $unsigned(acc_sum);

    // Stage 2: register the ReLU'd result; pixel_out holds between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            pix_out_q <= '0;
        end else begin
            valid_q <= win_vld_q;
            done_q  <= win_vld_q && win_last_q;
            if (win_vld_q) pix_out_q <= DATA_WIDTH'(relu_val);
        end
    end

    assign valid_out  = valid_q;
    assign frame_done = done_q;
    assign pixel_out  = pix_out_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_conv3x3_relu_stream.sv
// Directed bench for conv3x3_relu_stream: weight loading, frames, gaps, back-to-back, reset.
// Latency: checks every result lands exactly 2 cycles after its completing pixel.
// Backpressure: none exercised; the stream is push-only.
module tb_conv3x3_relu_stream;

    localparam int W    = 20;
    localparam int H    = 20;
    localparam int NOUT = 324;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b1;
    logic              w_load   = 1'b0;
    logic signed [7:0] w_data   = '0;
    logic              valid_in = 1'b0;
    logic        [7:0] pixel_in = '0;
    logic              valid_out, frame_done, busy;
    logic       [23:0] pixel_out;

    conv3x3_relu_stream dut (
        .clk(clk), .rst_n(rst_n), .w_load(w_load), .w_data(w_data),
        .valid_in(valid_in), .pixel_in(pixel_in), .valid_out(valid_out),
        .pixel_out(pixel_out), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int img [2][H][W];
    logic signed [7:0] wt [9];
    int got_val[$], got_cyc[$], got_fd[$], exp_cyc[$];
    int stray_fd = 0;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            got_val.push_back(int'(pixel_out));
            got_cyc.push_back(cyc);
            got_fd.push_back(int'(frame_done));
        end
        if (frame_done === 1'b1 && valid_out !== 1'b1) stray_fd++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick();
        valid_in = 1'b0;
        w_load   = 1'b0;
    endtask

    task automatic set_wt(input int v);
        for (int i = 0; i < 9; i++) wt[i] = 8'(v);
    endtask

    // kind 0: ramp (r*20+c)%256, 1: constant v, 2: random
    task automatic set_img(input int f, input int kind, input int v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[f][r][c] = (kind == 0) ? (r*W + c) % 256 :
                               (kind == 1) ? v : int'($urandom_range(0, 255));
    endtask

    task automatic load_weights(input bit with_pix);
        for (int i = 0; i < 9; i++) begin
            tick();
            w_load   = 1'b1;
            w_data   = wt[i];
            valid_in = with_pix;
            pixel_in = 8'd200;
        end
        idle();
    endtask

    task automatic send_frame(input int f, input int gap_pct, input bit noise, input int npix);
        int r, c;
        for (int idx = 0; idx < npix; idx++) begin
            r = idx / W;
            c = idx % W;
            while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                tick();
                valid_in = 1'b0;
                w_load   = noise && idx > 0 && ($urandom_range(0, 1) == 1);
                w_data   = 8'($urandom);
            end
            tick();
            valid_in = 1'b1;
            pixel_in = 8'(img[f][r][c]);
            w_load   = noise && idx > 0 && ($urandom_range(0, 1) == 1);
            w_data   = 8'($urandom);
            if (r >= 2 && c >= 2) exp_cyc.push_back(cyc);
        end
    endtask

    function automatic int ref_conv(input int f, input int r, input int c);
        int s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += img[f][r-2+i][c-2+j] * int'(wt[i*3+j]);
        return (s < 0) ? 0 : s;
    endfunction

    // mode 0: identity on ramp, 1: constant cval, 2: reference convolution
    task automatic drain_check(input string tag, input int mode, input int cval, input int nfr);
        int f, kk, r, c, e;
        repeat (10) tick();
        chk({tag, ":idle_after"}, 32'(busy), 32'd0);
        chk({tag, ":count"}, 32'(got_val.size()), 32'(nfr * NOUT));
        chk({tag, ":stray_fd"}, 32'(stray_fd), 32'd0);
        for (int k = 0; k < got_val.size() && k < nfr * NOUT; k++) begin
            f  = k / NOUT;
            kk = k % NOUT;
            r  = kk / 18 + 2;
            c  = kk % 18 + 2;
            e  = (mode == 0) ? ((r-1)*W + (c-1)) % 256 :
                 (mode == 1) ? cval : ref_conv(f, r, c);
            chk($sformatf("%s:val[%0d]", tag, k), 32'(got_val[k]), 32'(e));
            chk($sformatf("%s:fd[%0d]", tag, k), 32'(got_fd[k]), 32'(kk == NOUT-1));
            if (k < exp_cyc.size())
                chk($sformatf("%s:lat[%0d]", tag, k), 32'(got_cyc[k] - exp_cyc[k]), 32'd2);
        end
        got_val.delete();
        got_cyc.delete();
        got_fd.delete();
        exp_cyc.delete();
        stray_fd = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst:valid_out", 32'(valid_out), 32'd0);
        chk("rst:frame_done", 32'(frame_done), 32'd0);
        chk("rst:pixel_out", 32'(pixel_out), 32'd0);
        chk("rst:busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Junk load with valid_in high: pixels must be dropped; then 9 more loads wrap widx.
        set_wt(7);
        load_weights(1'b1);
        chk("wload_prio:busy", 32'(busy), 32'd0);
        set_wt(0);
        wt[4] = 8'sd1;
        load_weights(1'b0);
        set_img(0, 0, 0);
        send_frame(0, 0, 1'b0, W*H);
        idle();
        drain_check("ramp_id", 0, 0, 1);

        set_wt(1);
        load_weights(1'b0);
        set_img(0, 1, 10);
        send_frame(0, 0, 1'b0, W*H);
        idle();
        drain_check("ones_10", 1, 90, 1);

        set_wt(127);
        load_weights(1'b0);
        set_img(0, 1, 255);
        send_frame(0, 0, 1'b0, W*H);
        idle();
        drain_check("max", 1, 291465, 1);

        set_wt(0);
        wt[4] = -8'sd1;
        load_weights(1'b0);
        set_img(0, 0, 0);
        send_frame(0, 0, 1'b0, W*H);
        idle();
        drain_check("neg_relu", 1, 0, 1);

        set_wt(0);
        wt[4] = 8'sd1;
        load_weights(1'b0);
        send_frame(0, 50, 1'b0, W*H);
        idle();
        drain_check("gaps", 0, 0, 1);

        // Random kernel, w_load noise during RUN, two frames back to back.
        for (int i = 0; i < 9; i++) wt[i] = 8'(int'($urandom_range(0, 20)) - 10);
        wt[0] = -8'sd9;
        wt[8] = 8'sd5;
        load_weights(1'b0);
        set_img(0, 2, 0);
        set_img(1, 2, 0);
        send_frame(0, 0, 1'b1, W*H);
        send_frame(1, 0, 1'b1, W*H);
        idle();
        drain_check("b2b", 2, 0, 2);

        // Reset mid-frame while results are streaming out.
        set_img(0, 2, 0);
        send_frame(0, 0, 1'b0, 150);
        tick();
        valid_in = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst:valid_out", 32'(valid_out), 32'd0);
        chk("midrst:frame_done", 32'(frame_done), 32'd0);
        chk("midrst:pixel_out", 32'(pixel_out), 32'd0);
        chk("midrst:busy", 32'(busy), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        got_val.delete();
        got_cyc.delete();
        got_fd.delete();
        exp_cyc.delete();
        stray_fd = 0;
        for (int i = 0; i < 9; i++) wt[i] = 8'(i - 4);
        load_weights(1'b0);
        set_img(0, 2, 0);
        send_frame(0, 0, 1'b0, W*H);
        idle();
        drain_check("post_rst", 2, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv3x3_relu_stream.md
CONV3X3_RELU_STREAM -- requirements
Module: conv3x3_relu_stream

Interface
REQ-001 SHALL have parameter PIX_WIDTH, default 8, unsigned input pixel width.
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 8, signed two's-complement weight width.
REQ-003 SHALL have parameter DATA_WIDTH, default 24, output width, equal to the downstream 2x2 max-pool DATA_WIDTH.
REQ-004 SHALL have parameters IMG_WIDTH and IMG_HEIGHT, default 20 each; both SHALL be at least 3. Kernel size is fixed at 3.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port w_load, input, 1 bit: weight write strobe.
REQ-008 SHALL have port w_data, input, WEIGHT_WIDTH bits: weight value.
REQ-009 SHALL have port valid_in, input, 1 bit: pixel_in is valid this cycle. There is no backpressure.
REQ-010 SHALL have port pixel_in, input, PIX_WIDTH bits: raster-order pixel, row-major, unsigned.
REQ-011 SHALL have port valid_out, output, 1 bit: pixel_out is valid this cycle. This is a single-cycle strobe per result.
REQ-012 SHALL have port pixel_out, output, DATA_WIDTH bits: ReLU'd convolution result, zero-extended.
REQ-013 SHALL have port frame_done, output, 1 bit: pulses high together with the last valid_out of a frame.
REQ-014 SHALL have port busy, output, 1 bit: high when the FSM is not IDLE.

Function
REQ-015 SHALL keep 9 weights W[0..8] in row-major order (W[0] top-left, W[8] bottom-right); each w_load in IDLE SHALL write w_data to W[widx], then widx SHALL wrap 8->0.
REQ-016 SHALL ignore w_load outside IDLE, leaving the weights and widx unchanged.
REQ-017 SHALL give w_load priority over valid_in in IDLE if both are high in the same cycle: the weight is written and the pixel is dropped.
REQ-018 SHALL implement an FSM with states IDLE, RUN and DRAIN: IDLE->RUN on an accepted pixel; RUN->DRAIN on acceptance of the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1); DRAIN->IDLE when the last result is emitted; valid_in in DRAIN SHALL be accepted as pixel (0,0) of the next frame and SHALL move the FSM to RUN.
REQ-019 SHALL track the input column/row counters on accepted pixels only, and the counters SHALL wrap to (0,0) after the last pixel of the frame.
REQ-020 SHALL buffer the two previous image rows in line buffers of IMG_WIDTH entries each, plus a 3x3 window shift register, updating them only on accepted pixels.
REQ-021 SHALL produce one result per accepted pixel at input (r,c) with r>=2 and c>=2; the result covers input rows r-2..r and columns c-2..c, and no result SHALL be produced at other positions (no window wrap across row ends).
REQ-022 SHALL produce (IMG_WIDTH-2)*(IMG_HEIGHT-2) results per frame (324 at defaults), in raster order.
REQ-023 SHALL assert valid_out exactly 2 cycles after the completing pixel's valid_in cycle: cycle 1 registers the window, cycle 2 registers the MAC result. Latency is fixed regardless of later input gaps.
REQ-024 SHALL compute each product as the pixel zero-extended to signed PIX_WIDTH+1 bits times the weight, and the sum in at least 21 signed bits with no overflow possible at the defaults (range -293760..+291465).
REQ-025 SHALL apply ReLU (negative sum -> 0) and zero-extend the sum to DATA_WIDTH; pixel_out SHALL therefore be unsigned-comparable downstream.
REQ-026 SHALL hold pixel_out at its last value when valid_out is low.

Reset
REQ-027 SHALL on rst_n low, at any time including mid-frame, immediately clear: valid_out, frame_done, pixel_out, busy, all weights, widx, the counters, the window and both pipeline stages, and set the FSM to IDLE.
REQ-028 SHALL NOT require clearing line buffer contents, but SHALL NOT emit any result from pre-reset data after reset is released.

Structure
REQ-029 SHALL take IMG_WIDTH, IMG_HEIGHT, KERNEL=3, DATA_WIDTH and the pixel/weight/accumulator typedefs and the FSM state enum from the shared CNN package, which the max-pool stage also uses.
REQ-030 SHALL instantiate one sub-module, line_buffer: a parameterised-width, depth-IMG_WIDTH single-row delay with an enable input; it SHALL be instantiated twice.

Verification
REQ-031 SHALL verify: W[4]=1, others 0; 20x20 ramp pixel=(r*20+c)%256 -> 324 outputs, output k = input at (k/18+1, k%18+1), with frame_done on the 324th output.
REQ-032 SHALL verify: all W=1; constant image 10 -> 324 outputs of 90; all W=127, image 255 -> 291465 on every output.
REQ-033 SHALL verify: W[4]=-1, others 0; any image -> all 324 outputs 0, valid_out count still 324.
REQ-034 SHALL verify: identity kernel, valid_in randomly low ~50% of cycles -> same 324 values as contiguous input, each exactly 2 cycles after its completing pixel.
REQ-035 SHALL verify: w_load pulses during RUN -> weights unchanged; back-to-back frames (frame 2 pixel 0 in DRAIN) -> both frames produce 324 correct outputs each.
REQ-036 SHALL verify: rst_n low after pixel 150, then a fresh weight load and a full frame -> no stale outputs, and exactly 324 correct outputs.
